ieee_adder_arbiter: RTL and testbench

- Shares one single-precision ieee_adder datapath (prepare → compare → shift → swap → add/sub → normalize → round → final) between NUM_REQ requesters.
- Arbitrates requests round-robin, registers the winning operands onto the adder inputs, and tracks each in-flight operation's owner through a tag pipeline matched to the adder latency.
- Returns each result as a one-cycle pulse to its owner.
- Sits between client blocks (accumulators, dot-product sequencers) and the adder core instance.

---
 rtl/ieee_adder_arbiter.sv | 116 +++++++++++
 tb/tb_ieee_adder_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee_adder_arbiter.sv
// Round-robin arbiter that shares one single-precision adder core among NUM_REQ clients.
// A tag pipeline the depth of the core latency routes each result back to its owner.
module ieee_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic                  add_valid,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_sub,
  input  logic [31:0]           add_result,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_result,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAST = ADD_LAT;

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               accept;
  logic [NUM_REQ-1:0] accept_onehot;
  logic [NUM_REQ-1:0] resp_onehot;
  logic [ADD_LAT:0]   tag_valid;
  logic [ID_W-1:0]    tag_id [ADD_LAT+1];

  // Client index base+off, wrapped into 0..NUM_REQ-1 (off is at most NUM_REQ-1).
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default before any condition, so no latch can be inferred.
  always_comb begin
    eligible  = req_valid & ~pending;
    win_found = 1'b0;
    win_id    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_found && eligible[wrap_inc(rr_ptr, off)]) begin
        win_found = 1'b1;
        win_id    = wrap_inc(rr_ptr, off);
      end
    end
  end

  assign accept = win_found && !reset;

  always_comb begin
    accept_onehot = '0;
    resp_onehot   = '0;
    if (accept) accept_onehot[win_id] = 1'b1;
    if (tag_valid[LAST]) resp_onehot[tag_id[LAST]] = 1'b1;
  end

  assign req_ready = accept_onehot;
  assign busy      = |pending;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_valid   <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      add_sub     <= 1'b0;
      resp_valid  <= '0;
      resp_result <= '0;
      ops_done    <= '0;
      rr_ptr      <= '0;
      pending     <= '0;
      tag_valid   <= '0;
    end else begin
      add_valid <= accept;
      if (accept) begin
        add_a   <= req_a[32*win_id +: 32];
        add_b   <= req_b[32*win_id +: 32];
        add_sub <= req_sub[win_id];
        rr_ptr  <= wrap_inc(win_id, 1);
      end

      tag_valid[0] <= accept;
      for (int i = 1; i <= ADD_LAT; i++) tag_valid[i] <= tag_valid[i-1];

      // Pending set and clear never hit the same client: a pending client is never eligible.
      resp_valid <= resp_onehot;
      pending    <= (pending & ~resp_onehot) | accept_onehot;
      if (tag_valid[LAST]) begin
        resp_result <= add_result;
        ops_done    <= ops_done + CNT_W'(1);
      end
    end
  end

  // NOTE: tag ids are storage qualified by tag_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) tag_id[0] <= win_id;
    for (int i = 1; i <= ADD_LAT; i++) tag_id[i] <= tag_id[i-1];
  end

endmodule

// File: tb/tb_ieee_adder_arbiter.sv
// Bench for ieee_adder_arbiter: a combinational-core instance checked against a
// scoreboard every cycle, plus a 3-cycle-latency instance with a 3-bit op counter.
module tb_ieee_adder_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stand-in adder core: exact float results for the directed pairs, integer math otherwise.
  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
    if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (sub && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return sub ? a - b : a + b;
  endfunction

  // Instance 0: ADD_LAT = 0
  logic            rst0;
  logic [N-1:0]    rv0, rdy0, rs0, respv0;
  logic [32*N-1:0] ra0, rb0;
  logic            av0, as0, busy0;
  logic [31:0]     aa0, ab0, ares0, resr0;
  logic [15:0]     ops0;

  assign ares0 = core_fn(aa0, ab0, as0);

  ieee_adder_arbiter #(.NUM_REQ(N), .ADD_LAT(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(rst0),
    .req_valid(rv0), .req_ready(rdy0), .req_a(ra0), .req_b(rb0), .req_sub(rs0),
    .add_valid(av0), .add_a(aa0), .add_b(ab0), .add_sub(as0), .add_result(ares0),
    .resp_valid(respv0), .resp_result(resr0), .busy(busy0), .ops_done(ops0)
  );

  // Instance 3: ADD_LAT = 3, 3-bit counter so wrap is reachable
  logic            rst3;
  logic [N-1:0]    rv3, rdy3, rs3, respv3;
  logic [32*N-1:0] ra3, rb3;
  logic            av3, as3, busy3;
  logic [31:0]     aa3, ab3, ares3, resr3;
  logic [2:0]      ops3;
  logic [31:0]     pipe3 [3];

  always @(posedge clk) begin
    pipe3[0] <= core_fn(aa3, ab3, as3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ares3 = pipe3[2];

  ieee_adder_arbiter #(.NUM_REQ(N), .ADD_LAT(3), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(rst3),
    .req_valid(rv3), .req_ready(rdy3), .req_a(ra3), .req_b(rb3), .req_sub(rs3),
    .add_valid(av3), .add_a(aa3), .add_b(ab3), .add_sub(as3), .add_result(ares3),
    .resp_valid(respv3), .resp_result(resr3), .busy(busy3), .ops_done(ops3)
  );

  // Scoreboard and reference state for instance 0
  typedef struct {
    int          id;
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t         sb[$];
  int           glog[$];
  int           gcyc[$];
  int           rlog[$];
  bit           mon_en = 1'b0;
  logic [N-1:0] m_pend = '0;
  int           m_rr = 0;
  int           m_ops = 0;
  logic         m_av = 1'b0;
  logic         m_as = 1'b0;
  logic [31:0]  m_aa = '0;
  logic [31:0]  m_ab = '0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rv, exp_rdy, elig;
    int           w;
    exp_t         e;
    if (mon_en) begin
      exp_rv = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_rv[sb[0].id] = 1'b1;
        check("sb_resp_result", resr0, sb[0].res);
        m_pend[sb[0].id] = 1'b0;
        m_ops++;
        rlog.push_back(sb[0].id);
        void'(sb.pop_front());
      end
      check("sb_resp_valid", respv0, exp_rv);
      check("sb_ops_done", ops0, m_ops);
      check("sb_busy", busy0, |m_pend);
      check("sb_add_valid", av0, m_av);
      check("sb_add_a", aa0, m_aa);
      check("sb_add_b", ab0, m_ab);
      check("sb_add_sub", as0, m_as);

      exp_rdy = '0;
      w = -1;
      if (!rst0) begin
        elig = rv0 & ~m_pend;
        for (int k = 0; k < N; k++)
          if (w < 0 && elig[(m_rr + k) % N]) w = (m_rr + k) % N;
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      check("sb_req_ready", rdy0, exp_rdy);

      m_av = (w >= 0);
      if (w >= 0) begin
        m_aa  = ra0[32*w +: 32];
        m_ab  = rb0[32*w +: 32];
        m_as  = rs0[w];
        e.id  = w;
        e.res = core_fn(m_aa, m_ab, m_as);
        e.due = cyc + 2;
        sb.push_back(e);
        m_pend[w] = 1'b1;
        m_rr = (w + 1) % N;
        glog.push_back(w);
        gcyc.push_back(cyc);
      end

      if (rst0) begin
        sb.delete();
        m_pend = '0;
        m_rr   = 0;
        m_ops  = 0;
        m_av   = 1'b0;
        m_aa   = '0;
        m_ab   = '0;
        m_as   = 1'b0;
      end
    end
  end

  task automatic issue0(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic sub);
    ra0[32*id +: 32] = a;
    rb0[32*id +: 32] = b;
    rs0[id] = sub;
    rv0[id] = 1'b1;
    step();
    rv0[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [3:0]  exp_rv3;
  logic [31:0] r1, r3, r0w;
  int          n;

  initial begin
    rst0 = 1'b1; rv0 = '0; ra0 = '0; rb0 = '0; rs0 = '0;
    rst3 = 1'b1; rv3 = '0; ra3 = '0; rb3 = '0; rs3 = '0;
    repeat (3) step();

    check("rst_add_valid", av0, 0);
    check("rst_add_a", aa0, 0);
    check("rst_add_b", ab0, 0);
    check("rst_add_sub", as0, 0);
    check("rst_resp_valid", respv0, 0);
    check("rst_resp_result", resr0, 0);
    check("rst_busy", busy0, 0);
    check("rst_ops_done", ops0, 0);
    check("rst_req_ready", rdy0, 0);
    check("rst3_add_valid", av3, 0);
    check("rst3_ops_done", ops3, 0);
    mon_en = 1'b1;
    rst0 = 1'b0;
    step();

    // Single add
    issue0(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    check("t1_add_valid", av0, 1);
    step();
    check("t1_resp_valid", respv0, 4'b0001);
    check("t1_resp_result", resr0, 32'h4040_0000);
    check("t1_ops_done", ops0, 1);

    // Subtract, then exact cancel
    issue0(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    step();
    check("t2_resp_valid", respv0, 4'b0100);
    check("t2_sub_result", resr0, 32'h4000_0000);
    issue0(2, 32'h4040_0000, 32'h4040_0000, 1'b1);
    step();
    check("t2_cancel_result", resr0, 32'h0000_0000);
    check("t2_ops_done", ops0, 3);

    // All clients requesting continuously right after reset
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    glog.delete();
    rlog.delete();
    rv0 = 4'hF;
    for (int i = 0; i < 12; i++) begin
      ra0 = {$urandom, $urandom, $urandom, $urandom};
      rb0 = {$urandom, $urandom, $urandom, $urandom};
      rs0 = 4'($urandom);
      step();
    end
    rv0 = '0;
    repeat (4) step();
    check("rr_grant_count", glog.size(), 12);
    check("rr_resp_count", rlog.size(), 12);
    if (glog.size() >= 8 && rlog.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        check($sformatf("rr_grant_%0d", i), glog[i], i % N);
        check($sformatf("rr_resp_%0d", i), rlog[i], i % N);
      end

    // Reset one cycle after an accept
    issue0(1, 32'h0000_0100, 32'h0000_0001, 1'b0);
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    repeat (3) step();
    check("rst_mid_ops_done", ops0, 0);
    check("rst_mid_busy", busy0, 0);
    ra0[0 +: 32] = 32'h0000_0007; rb0[0 +: 32] = 32'h0000_0003; rs0 = '0;
    ra0[96 +: 32] = 32'h0000_0009; rb0[96 +: 32] = 32'h0000_0002;
    rv0 = 4'b1001;
    #1;
    check("rst_next_grant", rdy0, 4'b0001);
    step();
    rv0 = '0;
    repeat (3) step();

    // One client holding its request: re-accepted in each response cycle
    glog.delete();
    gcyc.delete();
    ra0[0 +: 32] = 32'h0000_0042; rb0[0 +: 32] = 32'h0000_0002; rs0[0] = 1'b1;
    rv0 = 4'b0001;
    repeat (10) step();
    rv0 = '0;
    check("rereq_accepts", glog.size(), 5);
    if (gcyc.size() >= 2) check("rereq_period", gcyc[1] - gcyc[0], 2);
    repeat (3) step();

    // ADD_LAT = 3: back-to-back accepts for clients 1 and 3
    rst3 = 1'b0;
    step();
    ra3[32 +: 32] = 32'h0000_1234; rb3[32 +: 32] = 32'h0000_0011; rs3[1] = 1'b0;
    ra3[96 +: 32] = 32'h0000_5000; rb3[96 +: 32] = 32'h0000_0100; rs3[3] = 1'b1;
    r1 = core_fn(32'h0000_1234, 32'h0000_0011, 1'b0);
    r3 = core_fn(32'h0000_5000, 32'h0000_0100, 1'b1);
    rv3 = 4'b1010;
    for (int k = 1; k <= 7; k++) begin
      step();
      rv3 = (k == 1) ? 4'b1000 : 4'b0000;
      exp_rv3 = (k == 5) ? 4'b0010 : (k == 6) ? 4'b1000 : 4'b0000;
      check($sformatf("lat3_resp_valid_%0d", k), respv3, exp_rv3);
      check($sformatf("lat3_busy_%0d", k), busy3, k <= 5);
      check($sformatf("lat3_add_valid_%0d", k), av3, k <= 2);
      if (k == 1) check("lat3_add_a_c1", aa3, 32'h0000_1234);
      if (k == 2) check("lat3_add_a_c3", aa3, 32'h0000_5000);
      if (k == 2) check("lat3_add_sub_c3", as3, 1);
      if (k == 5) check("lat3_result_c1", resr3, r1);
      if (k == 6) check("lat3_result_c3", resr3, r3);
    end
    check("lat3_ops_done", ops3, 2);

    // Six more ops from client 0 push the 3-bit counter through its wrap
    ra3[0 +: 32] = 32'h0000_0300; rb3[0 +: 32] = 32'h0000_0021; rs3[0] = 1'b0;
    r0w = core_fn(32'h0000_0300, 32'h0000_0021, 1'b0);
    n = 0;
    rv3 = 4'b0001;
    for (int t = 0; t < 80 && n < 6; t++) begin
      step();
      if (respv3[0]) begin
        n++;
        check($sformatf("wrap_ops_done_%0d", n), ops3, (2 + n) % 8);
        check($sformatf("wrap_result_%0d", n), resr3, r0w);
        if (n == 6) rv3 = '0;
      end
    end
    rv3 = '0;
    check("wrap_pulses", n, 6);
    repeat (6) step();
    check("wrap_final_ops_done", ops3, 0);
    check("wrap_final_busy", busy3, 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
